shift_out_reg: RTL and testbench

SHIFT_OUT_REG -- requirements
Module: shift_out_reg

---
 rtl/shift_out_reg.sv | 105 ++++++++++
 tb/tb_shift_out_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shift_out_reg.sv
// Parallel-in, serial-out shifter with IDLE/SHIFT/DONE handshake, state on the falling clock edge.
// Define SHIFT_OUT_REG_LSB_FIRST_EN to emit DIn[0] first; MSB first otherwise.
module shift_out_reg #(
   parameter int DataWidth = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 LD,
   input  logic [DataWidth-1:0] DIn,
   input  logic                 Stall,
   output logic                 Ready,
   output logic                 SOut,
   output logic                 SValid,
   output logic                 Done
);

   localparam int CntW = $clog2(DataWidth) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(DataWidth - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DataWidth-1:0] sr_q, sr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 head;
   logic [DataWidth-1:0] sr_adv;

`ifdef SHIFT_OUT_REG_LSB_FIRST_EN
   assign head   = sr_q[0];
   assign sr_adv = sr_q >> 1;
`else
   assign head   = sr_q[DataWidth-1];
   assign sr_adv = sr_q << 1;
`endif

   always_ff @(negedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

   // LD is only looked at in IDLE, so a word in flight can never be overwritten.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (!LD) begin
               sr_d    = DIn;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!Stall) begin
               sr_d  = sr_adv;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastCnt) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      Ready  = 1'b0;
      SOut   = 1'b0;
      SValid = 1'b0;
      Done   = 1'b0;
      case (state_q)
         IDLE: begin
            Ready = 1'b1;
         end
         SHIFT: begin
            SValid = 1'b1;
            SOut   = head;
         end
         DONE: begin
            Done = 1'b1;
         end
         default: begin
            Ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_out_reg.sv
// Directed bench for shift_out_reg: expected serial bits queued at load time, popped as they are consumed.
module tb_shift_out_reg;

   logic       Clk;
   logic       Reset;
   logic       LD;
   logic [7:0] DIn;
   logic       Stall;
   logic       Ready, SOut, SValid, Done;

   logic       LD1;
   logic [0:0] DIn1;
   logic       Stall1;
   logic       Ready1, SOut1, SValid1, Done1;

   int total = 0;
   int bad   = 0;
   logic sbq[$];

   shift_out_reg #(.DataWidth(8)) dut (
      .Clk(Clk), .Reset(Reset), .LD(LD), .DIn(DIn), .Stall(Stall),
      .Ready(Ready), .SOut(SOut), .SValid(SValid), .Done(Done)
   );

   shift_out_reg #(.DataWidth(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .LD(LD1), .DIn(DIn1), .Stall(Stall1),
      .Ready(Ready1), .SOut(SOut1), .SValid(SValid1), .Done(Done1)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called on a rising edge; the load happens on the following falling edge.
   task automatic start_load(input logic [7:0] w, input logic stall_in_idle);
      Reset = 1'b0;
      LD    = 1'b0;
      DIn   = w;
      Stall = stall_in_idle;
`ifdef SHIFT_OUT_REG_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) sbq.push_back(w[i]);
`else
      for (int i = 7; i >= 0; i--) sbq.push_back(w[i]);
`endif
      @(posedge Clk);
      LD  = 1'b1;
      DIn = 8'($urandom);
   endtask

   task automatic run_word(input string name, input int stall_at, input int stall_len,
                           input int ld_at, input int rst_at, input int done_cyc);
      int k = 0;
      int bidx = 0;
      int stalled = 0;
      bit ld_done = 0;
      forever begin
         k++;
         if (k > 40) begin
            chk({name, "_timeout"}, 32'(k), 32'(done_cyc));
            Stall = 1'b0;
            LD    = 1'b1;
            sbq.delete();
            break;
         end
         if (sbq.size() == 0) begin
            Stall = 1'b0;
            LD    = 1'b1;
            chk({name, "_done"}, 32'(Done), 32'd1);
            chk({name, "_done_svalid"}, 32'(SValid), 32'd0);
            chk({name, "_done_ready"}, 32'(Ready), 32'd0);
            chk({name, "_done_cycle"}, 32'(k), 32'(done_cyc));
            @(posedge Clk);
            chk({name, "_ready_after"}, 32'(Ready), 32'd1);
            chk({name, "_done_one_cycle"}, 32'(Done), 32'd0);
            break;
         end
         chk({name, "_svalid"}, 32'(SValid), 32'd1);
         chk({name, "_ready_busy"}, 32'(Ready), 32'd0);
         chk({name, "_no_done"}, 32'(Done), 32'd0);
         chk($sformatf("%s_bit%0d", name, bidx), 32'(SOut), 32'(sbq[0]));
         if (bidx == rst_at) begin
            Reset = 1'b1;
            Stall = 1'b0;
            @(posedge Clk);
            chk({name, "_rst_svalid"}, 32'(SValid), 32'd0);
            chk({name, "_rst_ready"}, 32'(Ready), 32'd1);
            chk({name, "_rst_nodone"}, 32'(Done), 32'd0);
            chk({name, "_rst_sout"}, 32'(SOut), 32'd0);
            sbq.delete();
            break;
         end
         if (bidx == ld_at && !ld_done) begin
            LD      = 1'b0;
            DIn     = 8'h00;
            ld_done = 1;
         end else begin
            LD = 1'b1;
         end
         if (bidx == stall_at && stalled < stall_len) begin
            Stall = 1'b1;
            stalled++;
         end else begin
            Stall = 1'b0;
            void'(sbq.pop_front());
            bidx++;
         end
         @(posedge Clk);
      end
   endtask

   initial begin
      Reset  = 1'b1;
      LD     = 1'b1;
      DIn    = 8'h00;
      Stall  = 1'b0;
      LD1    = 1'b1;
      DIn1   = 1'b0;
      Stall1 = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      chk("rst_ready", 32'(Ready), 32'd1);
      chk("rst_svalid", 32'(SValid), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_sout", 32'(SOut), 32'd0);
      chk("rst1_ready", 32'(Ready1), 32'd1);
      chk("rst1_svalid", 32'(SValid1), 32'd0);

      // Load on the first edge after reset release, then back-to-back words.
      start_load(8'hA5, 1'b0);
      run_word("a5", -1, 0, -1, -1, 9);
      start_load(8'h5A, 1'b1);
      run_word("5a", -1, 0, -1, -1, 9);
      start_load(8'hF0, 1'b0);
      run_word("f0_stall", 1, 3, -1, -1, 12);

      start_load(8'hFF, 1'b0);
      run_word("ff_ld", -1, 0, 3, -1, 9);
      @(posedge Clk);
      chk("ff_ld_not_captured", 32'(SValid), 32'd0);
      chk("ff_ld_idle", 32'(Ready), 32'd1);

      start_load(8'hC3, 1'b0);
      run_word("c3_rst", -1, 0, -1, 4, 9);
      start_load(8'h3C, 1'b0);
      run_word("3c", -1, 0, -1, -1, 9);

      LD1  = 1'b0;
      DIn1 = 1'b1;
      @(posedge Clk);
      LD1  = 1'b1;
      DIn1 = 1'b0;
      chk("w1_svalid", 32'(SValid1), 32'd1);
      chk("w1_sout", 32'(SOut1), 32'd1);
      chk("w1_ready_busy", 32'(Ready1), 32'd0);
      @(posedge Clk);
      chk("w1_done", 32'(Done1), 32'd1);
      chk("w1_done_svalid", 32'(SValid1), 32'd0);
      @(posedge Clk);
      chk("w1_ready", 32'(Ready1), 32'd1);
      chk("w1_done_clear", 32'(Done1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
